// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// The parity helper is also used by the matching receiver.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_STOP_BITS  = 1;
  localparam int FRAME_LEN      = 2 + DEF_DATA_WIDTH + DEF_STOP_BITS;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Zero-extension does not change the XOR, so narrower words can be widened freely.
  function automatic logic odd_parity(input logic [31:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry valid/ready holding buffer in front of the transmit shifter.
// ready is a register, so valid never reaches ready combinationally.
module tx_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             valid,
  output logic             ready,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] hold_data
);

  logic [WIDTH-1:0] data_reg;
  logic             full_reg;
  logic             full_next;
  logic             ready_reg;
  logic             accept;

  assign accept = valid & ready_reg;

  // Accept and drain are mutually exclusive: accept needs empty, drain needs full.
  always_comb begin
    full_next = full_reg;
    if (accept) begin
      full_next = 1'b1;
    end else if (drain) begin
      full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      full_reg  <= 1'b0;
      ready_reg <= 1'b1;
      data_reg  <= '0;
    end else begin
      full_reg  <= full_next;
      ready_reg <= ~full_next;
      if (accept) begin
        data_reg <= push_data;
      end
    end
  end

  assign ready     = ready_reg;
  assign full      = full_reg;
  assign hold_data = data_reg;

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start, data LSB first, odd parity, stop bit(s).
// One bit position per enabled clock; back-to-back frames with no idle gap.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in_byte,
  input  logic                  valid,
  output logic                  ready,
  output logic                  out_bit,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t             state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic                  stop_cnt_reg, stop_cnt_next;
  logic                  parity_reg, parity_next;
  logic                  out_reg, out_next;
  logic                  done_reg, done_next;

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  drain;

  tx_hold_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk      (clk),
    .arst     (arst),
    .push_data(in_byte),
    .valid    (valid),
    .ready    (ready),
    .drain    (drain),
    .full     (hold_full),
    .hold_data(hold_data)
  );

  // out_next is the level of the bit position being entered on this edge.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    out_next      = out_reg;
    done_next     = 1'b0;
    drain         = 1'b0;

    if (en) begin
      case (state_reg)
        ST_IDLE: begin
          out_next = LINE_IDLE;
          drain    = hold_full;
        end
        ST_START: begin
          out_next     = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_reg == LAST_BIT) begin
            out_next   = parity_reg;
            state_next = ST_PARITY;
          end else begin
            out_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
        ST_PARITY: begin
          out_next      = LINE_STOP;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_reg == LAST_STOP) begin
            done_next  = 1'b1;
            out_next   = LINE_IDLE;
            state_next = ST_IDLE;
            drain      = hold_full;
          end else begin
            out_next      = LINE_STOP;
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
        default: begin
          out_next   = LINE_IDLE;
          state_next = ST_IDLE;
        end
      endcase

      // Loading the shifter overrides the idle/stop path so a queued byte starts at once.
      if (drain) begin
        shift_next  = hold_data;
        parity_next = odd_parity(32'(hold_data));
        out_next    = LINE_START;
        state_next  = ST_START;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      out_reg      <= LINE_IDLE;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      out_reg      <= out_next;
      done_reg     <= done_next;
    end
  end

  assign out_bit = out_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = done_reg;

endmodule
